// File: rtl/button_pkg.sv
// Shared types and constants for the button event arbiter.
// Also hosts the popcount helper used by the optional drop counter.
package button_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_t;

  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  // Number of set bits in a request-sized vector (at most 16 buttons).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping from NUM_BTNS-1 back to 0.
module rr_priority_picker
  import button_pkg::*;
#(
  parameter int NUM_BTNS = 4,
  parameter int IDX_W    = $clog2(NUM_BTNS)
) (
  input  logic [NUM_BTNS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                any_o
);

  // Scan requests in rotated order, keeping the first hit.
  always_comb begin
    int         raw;
    logic [IDX_W-1:0] cand;
    logic       hit;
    grant_idx_o = {IDX_W{1'b0}};
    any_o       = 1'b0;
    raw         = 0;
    cand        = {IDX_W{1'b0}};
    hit         = 1'b0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      raw         = int'(ptr_i) + i;
      raw         = (raw >= NUM_BTNS) ? (raw - NUM_BTNS) : raw;
      cand        = IDX_W'(raw);
      hit         = req_i[cand] & ~any_o;
      grant_idx_o = hit ? cand : grant_idx_o;
      any_o       = any_o | req_i[cand];
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Serializes button press pulses into a valid/ready event stream with
// round-robin fairness. Optional drop counter enabled by DROP_COUNT_EN.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter  int NUM_BTNS = 4,
  localparam int IDX_W    = $clog2(NUM_BTNS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_BTNS-1:0]   pulse_i,
  output logic                  event_valid_o,
  input  logic                  event_ready_i,
  output logic [IDX_W-1:0]      event_idx_o,
  output logic [NUM_BTNS-1:0]   pending_o
`ifdef DROP_COUNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count_o
`endif
);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [NUM_BTNS-1:0] pending_q, pending_d;
  logic [NUM_BTNS-1:0] clr_s;
  logic                handshake_s;
  logic [IDX_W-1:0]    next_ptr_s;
  logic [IDX_W-1:0]    pick_ptr_s;
  logic [IDX_W-1:0]    grant_s;
  logic                any_s;

  // Explicit wrap keeps non-power-of-2 button counts correct.
  assign handshake_s = (state_q == ARB_PRESENT) & event_ready_i;
  assign next_ptr_s  = (idx_q == IDX_W'(NUM_BTNS - 1)) ? {IDX_W{1'b0}}
                                                       : (idx_q + IDX_W'(1));
  assign pick_ptr_s  = handshake_s ? next_ptr_s : ptr_q;

  rr_priority_picker #(
    .NUM_BTNS (NUM_BTNS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req_i       (pending_q),
    .ptr_i       (pick_ptr_s),
    .grant_idx_o (grant_s),
    .any_o       (any_s)
  );

  // Next-state, grant and pointer update for the two-state arbiter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    clr_s   = {NUM_BTNS{1'b0}};
    case (state_q)
      ARB_IDLE: begin
        if (any_s) begin
          idx_d   = grant_s;
          clr_s   = NUM_BTNS'(1'b1) << grant_s;
          state_d = ARB_PRESENT;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_PRESENT: begin
        if (event_ready_i) begin
          ptr_d = next_ptr_s;
          if (any_s) begin
            idx_d   = grant_s;
            clr_s   = NUM_BTNS'(1'b1) << grant_s;
            state_d = ARB_PRESENT;
          end else begin
            state_d = ARB_IDLE;
          end
        end else begin
          state_d = ARB_PRESENT;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    // A new press in the grant cycle survives the clear.
    pending_d = (pending_q & ~clr_s) | pulse_i;
  end

  // Arbiter state, presented index, pointer and pending flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ARB_IDLE;
      idx_q     <= {IDX_W{1'b0}};
      ptr_q     <= {IDX_W{1'b0}};
      pending_q <= {NUM_BTNS{1'b0}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
    end
  end

  assign event_valid_o = (state_q == ARB_PRESENT);
  assign event_idx_o   = idx_q;
  assign pending_o     = pending_q;

`ifdef DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [NUM_BTNS-1:0]   drop_s;
  logic [DROP_CNT_W:0]   drop_sum_s;

  // A press is lost when its button is already pending and not being granted.
  always_comb begin
    drop_s     = pulse_i & pending_q & ~clr_s;
    drop_sum_s = {1'b0, drop_cnt_q} + (DROP_CNT_W + 1)'(popcount16(16'(drop_s)));
    if (drop_sum_s > {1'b0, DROP_CNT_MAX}) begin
      drop_cnt_d = DROP_CNT_MAX;
    end else begin
      drop_cnt_d = drop_sum_s[DROP_CNT_W-1:0];
    end
  end

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= {DROP_CNT_W{1'b0}};
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule
